// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that gives NUM_REQ requesters turns at a
// single-command memory port. Only one transaction is in flight at a time:
// IDLE -> ISSUE -> WAIT -> DONE -> IDLE. A transaction that sees no memory
// response within TIMEOUT WAIT cycles is aborted with err.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous, active-low reset
//   req        : per-requester request level
//   req_wr_rd  : per-requester direction (1 = write, 0 = read)
//   req_addr   : packed addresses, requester k in slice k
//   req_wdata  : packed write data, requester k in slice k
//   gnt        : one-hot grant, held from ISSUE through DONE
//   done       : one-cycle completion pulse to the granted requester
//   err        : one-cycle pulse together with done on a timeout abort
//   rd_data    : data from the most recent successful read
//   m_valid    : memory command strobe (one cycle per transaction)
//   m_wr_rd    : memory command direction
//   m_addr     : memory address
//   m_wdata    : memory write data
//   m_rdata    : memory read data
//   m_ready    : memory response, only honoured in WAIT
module mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int WIDTH      = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          m_valid,
  output logic                          m_wr_rd,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [WIDTH-1:0]              m_wdata,
  input  logic [WIDTH-1:0]              m_rdata,
  input  logic                          m_ready
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [PTR_W-1:0]        ptr_reg, ptr_next;
  logic [PTR_W-1:0]        idx_reg, idx_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [NUM_REQ-1:0]      gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]      done_reg, done_next;
  logic                    err_reg, err_next;
  logic [WIDTH-1:0]        rd_data_reg, rd_data_next;
  logic                    m_valid_reg, m_valid_next;
  logic                    m_wr_rd_reg, m_wr_rd_next;
  logic [ADDR_WIDTH-1:0]   m_addr_reg, m_addr_next;
  logic [WIDTH-1:0]        m_wdata_reg, m_wdata_next;

  // Unpacked views of the packed per-requester buses.
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [WIDTH-1:0]      wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
  end

  // Round-robin pick: first set request at or after ptr, wrapping.
  logic [PTR_W-1:0] sel;
  logic             found;
  int               rr_idx;

  always_comb begin
    sel    = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_idx = int'(ptr_reg) + i;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!found && req[PTR_W'(rr_idx)]) begin
        found = 1'b1;
        sel   = PTR_W'(rr_idx);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    gnt_next     = gnt_reg;
    done_next    = '0;
    err_next     = 1'b0;
    rd_data_next = rd_data_reg;
    m_valid_next = 1'b0;
    m_wr_rd_next = m_wr_rd_reg;
    m_addr_next  = m_addr_reg;
    m_wdata_next = m_wdata_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (found) begin
          idx_next      = sel;
          gnt_next      = '0;
          gnt_next[sel] = 1'b1;
          m_wr_rd_next  = req_wr_rd[sel];
          m_addr_next   = addr_arr[sel];
          m_wdata_next  = wdata_arr[sel];
          // Registered strobe: visible only during the ISSUE cycle.
          m_valid_next  = 1'b1;
          state_next    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // A response in the last allowed cycle still wins over the abort.
        if (m_ready) begin
          if (!m_wr_rd_reg) rd_data_next = m_rdata;
          done_next[idx_reg] = 1'b1;
          state_next         = S_DONE;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          done_next[idx_reg] = 1'b1;
          err_next           = 1'b1;
          state_next         = S_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        gnt_next   = '0;
        ptr_next   = (idx_reg == PTR_W'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      ptr_reg     <= '0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      gnt_reg     <= '0;
      done_reg    <= '0;
      err_reg     <= 1'b0;
      rd_data_reg <= '0;
      m_valid_reg <= 1'b0;
      m_wr_rd_reg <= 1'b0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      rd_data_reg <= rd_data_next;
      m_valid_reg <= m_valid_next;
      m_wr_rd_reg <= m_wr_rd_next;
      m_addr_reg  <= m_addr_next;
      m_wdata_reg <= m_wdata_next;
    end
  end

  assign gnt     = gnt_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign rd_data = rd_data_reg;
  assign m_valid = m_valid_reg;
  assign m_wr_rd = m_wr_rd_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: the bench plays the memory (array model) and
// predicts each transaction from the arbitration rules: winner = first
// requesting index at or after the round-robin pointer, fixed issue/done
// timing, TIMEOUT WAIT cycles before an abort.
module tb_mem_arbiter;
  localparam int N   = 4;
  localparam int AW  = 6;
  localparam int W   = 16;
  localparam int TO  = 15;
  localparam int AWT = N * AW;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     req_wr_rd = '0;
  logic [N*AW-1:0]  req_addr = '0;
  logic [N*W-1:0]   req_wdata = '0;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic             err;
  logic [W-1:0]     rd_data;
  logic             m_valid;
  logic             m_wr_rd;
  logic [AW-1:0]    m_addr;
  logic [W-1:0]     m_wdata;
  logic [W-1:0]     m_rdata = '0;
  logic             m_ready = 1'b0;

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr_rd(req_wr_rd),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rd_data(rd_data), .m_valid(m_valid), .m_wr_rd(m_wr_rd),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           ptr_m = 0;
  logic [W-1:0] exp_rd = '0;
  logic [W-1:0] mem_m [2**AW];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic scramble();
    req       = N'($urandom);
    req_wr_rd = N'($urandom);
    req_addr  = AWT'($urandom);
    req_wdata = {$urandom, $urandom};
  endtask

  task automatic set_port(input int k, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_wr_rd[k]          = wr;
    req_addr[k*AW +: AW]  = a;
    req_wdata[k*W +: W]   = d;
  endtask

  task automatic idle_cycle();
    scramble();
    req = '0;
    @(posedge clk); #1;
    check_eq("idle_gnt", 64'(gnt), 64'(0));
    check_eq("idle_valid", 64'(m_valid), 64'(0));
    check_eq("idle_done", 64'(done), 64'(0));
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_txn(input logic [N-1:0] r, input int k, input int rst_at, input logic drop);
    int            w;
    logic          wr;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic [N-1:0]  oh;
    logic          fin;
    logic          rdy;
    req = r;
    w   = pick(r, ptr_m);
    wr  = req_wr_rd[w];
    a   = req_addr[w*AW +: AW];
    d   = req_wdata[w*W +: W];
    oh  = '0;
    oh[w] = 1'b1;
    m_ready = 1'($urandom);   // not in WAIT: must be ignored
    m_rdata = W'($urandom);
    @(posedge clk); #1;
    $display("txn req=%b ptr=%0d winner=%0d wr=%0d addr=%0d k=%0d rst_at=%0d", r, ptr_m, w, wr, a, k, rst_at);
    check_eq("issue_gnt", 64'(gnt), 64'(oh));
    check_eq("issue_valid", 64'(m_valid), 64'(1));
    check_eq("issue_wr", 64'(m_wr_rd), 64'(wr));
    check_eq("issue_addr", 64'(m_addr), 64'(a));
    check_eq("issue_wdata", 64'(m_wdata), 64'(d));
    check_eq("issue_done", 64'(done), 64'(0));
    check_eq("issue_rd", 64'(rd_data), 64'(exp_rd));
    if (drop) req = '0;
    else scramble();
    m_ready = 1'($urandom);   // sampled while still issuing: ignored
    @(posedge clk); #1;
    fin = 1'b0;
    for (int c = 0; c < TO && !fin; c++) begin
      check_eq("wait_valid", 64'(m_valid), 64'(0));
      check_eq("wait_gnt", 64'(gnt), 64'(oh));
      check_eq("wait_addr", 64'(m_addr), 64'(a));
      rdy = (c == k) && (c != rst_at);
      m_ready = rdy;
      m_rdata = (rdy && !wr) ? mem_m[a] : W'($urandom);
      if (c == rst_at) begin
        #2 rst = 1'b0;
        #1;
        check_eq("rst_outputs", {gnt, done, err, rd_data, m_valid, m_wr_rd, m_addr, m_wdata}, 64'(0));
        @(posedge clk); #1;
        check_eq("rst_hold", {gnt, done, err, rd_data, m_valid, m_wr_rd, m_addr, m_wdata}, 64'(0));
        rst     = 1'b1;
        m_ready = 1'b0;
        ptr_m   = 0;
        exp_rd  = '0;
        return;
      end
      @(posedge clk); #1;
      if (rdy || c == TO - 1) begin
        if (rdy) begin
          if (wr) mem_m[a] = d;
          else exp_rd = mem_m[a];
        end
        check_eq("done_vec", 64'(done), 64'(oh));
        check_eq("done_err", 64'(err), 64'(!rdy));
        check_eq("done_rd", 64'(rd_data), 64'(exp_rd));
        check_eq("done_gnt", 64'(gnt), 64'(oh));
        fin = 1'b1;
      end else begin
        check_eq("wait_done", 64'(done), 64'(0));
        check_eq("wait_err", 64'(err), 64'(0));
      end
    end
    m_ready = 1'($urandom);   // DONE cycle: ignored
    @(posedge clk); #1;
    check_eq("post_gnt", 64'(gnt), 64'(0));
    check_eq("post_done", 64'(done), 64'(0));
    check_eq("post_err", 64'(err), 64'(0));
    check_eq("post_rd", 64'(rd_data), 64'(exp_rd));
    ptr_m = (w + 1) % N;
  endtask

  initial begin
    logic [N-1:0] r;
    int           k;
    int           ra;
    for (int i = 0; i < 2**AW; i++) mem_m[i] = W'($urandom);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {gnt, done, err, rd_data, m_valid, m_wr_rd, m_addr, m_wdata}, 64'(0));
    rst = 1'b1;

    // All requesting: strict rotation 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      scramble();
      run_txn(4'b1111, 0, -1, 1'b0);
    end

    // Write then read back address 5.
    set_port(0, 1'b1, 6'd5, 16'hA5A5);
    run_txn(4'b0001, 0, -1, 1'b0);
    set_port(0, 1'b0, 6'd5, 16'h0000);
    run_txn(4'b0001, 0, -1, 1'b0);
    check_eq("readback_a5a5", 64'(rd_data), 64'(16'hA5A5));

    // After requester 2, requester 3 precedes 0.
    scramble();
    run_txn(4'b0100, 1, -1, 1'b0);
    scramble();
    run_txn(4'b1001, 2, -1, 1'b0);

    // Timeout abort, and a response on the very last WAIT cycle.
    scramble();
    run_txn(4'b0010, TO + 4, -1, 1'b0);
    scramble();
    run_txn(4'b0110, TO - 1, -1, 1'b0);

    // Requester 1 drops its request during the transaction.
    scramble();
    run_txn(4'b0010, 3, -1, 1'b1);

    // Reset during WAIT, then requester 1 wins first from pointer 0.
    scramble();
    run_txn(4'b0100, 5, 2, 1'b0);
    scramble();
    run_txn(4'b1010, 0, -1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 350; i++) begin
      if ($urandom_range(0, 7) == 0) idle_cycle();
      scramble();
      r = N'($urandom);
      if (r == '0) r = N'(1 << $urandom_range(0, N - 1));
      req_addr = req_addr & {N{6'b000111}};   // small address set for reuse
      k  = $urandom_range(0, TO + 3);
      ra = ($urandom_range(0, 39) == 0) ? $urandom_range(0, TO - 1) : -1;
      run_txn(r, k, ra, 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
